// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART blocks (uart_tx, uart_rx, baud_rate_gen).
//   - uart_state_e : 3-bit frame state encoding used by the transmitter FSM
//   - UART_NB_DATA : default data bits per frame
//   - UART_N_OVS   : default baud ticks per start/data/parity bit
//   - UART_SB_TICK : default baud ticks spent in the stop bit
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_NB_DATA = 8;
    localparam int UART_N_OVS   = 16;
    localparam int UART_SB_TICK = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//   Serialises one NB_DATA-bit word per request onto an asynchronous line,
//   LSB first, paced by an external N_OVS-times-oversampling baud tick.
//   Frame: start(0), NB_DATA data bits, optional even parity, stop(1).
//
//   Build option: define UART_TX_PARITY_EN to insert an even-parity bit
//   after the data bits. Ports and parameters are the same in both builds.
//
//   Handshake: the request is a level. In IDLE, any rising edge that sees
//   i_tx_start=1 accepts the word on i_data; o_busy rises from that edge.
//   Requests while o_busy=1 are dropped, not queued. The o_tx_done cycle is
//   already idle, so a request held during it is accepted back-to-back.
//
// Ports
//   i_clk       in   system clock, rising edge
//   i_rst       in   synchronous reset, active low
//   i_tick      in   one-cycle baud tick at N_OVS x baud rate
//   i_tx_start  in   request to send i_data
//   i_data      in   word to send, sampled on the accept edge
//   o_tx        out  serial line, idle high
//   o_busy      out  high while a frame is in progress
//   o_tx_done   out  one-cycle pulse at end of stop bit
//
// The internal state register (state_q) is a plain enum signal so checkers
// can bind to it directly.
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA = UART_NB_DATA,
    parameter int SB_TICK = UART_SB_TICK,
    parameter int N_OVS   = UART_N_OVS
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_tx_done
);

    // One counter serves both bit periods and the stop period, so size it
    // for whichever is longer.
    localparam int TICK_MAX = (SB_TICK > N_OVS) ? SB_TICK : N_OVS;
    localparam int TICK_W   = $clog2(TICK_MAX) + 1;
    localparam int BIT_W    = $clog2(NB_DATA) + 1;

    localparam logic [TICK_W-1:0] OVS_LAST  = TICK_W'(N_OVS - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NB_DATA - 1);

    uart_state_e        state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic               tx_d, busy_d, done_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            o_tx      <= 1'b1;
            o_busy    <= 1'b0;
            o_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            o_tx      <= tx_d;
            o_busy    <= busy_d;
            o_tx_done <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    // Every non-idle state advances only on i_tick; cycles without a tick
    // leave all state untouched, so bit time is N_OVS ticks at any clock ratio.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // A tick coinciding with the accept is deliberately not counted.
                if (i_tx_start) begin
                    state_d  = ST_START;
                    tick_d   = '0;
                    bit_d    = '0;
                    shift_d  = i_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^i_data;
`endif
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (tick_q == OVS_LAST) begin
                        state_d = ST_DATA;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (tick_q == OVS_LAST) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (i_tick) begin
                    if (tick_q == OVS_LAST) begin
                        state_d = ST_STOP;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (i_tick) begin
                    if (tick_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // Outputs are decoded from the next state and registered, so the line
    // changes on the same edge as the state it belongs to.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//   Directed bench for uart_tx. A frame model tracks, per accepted word, how
//   many baud ticks have elapsed and derives the expected line level, busy
//   and done from the frame layout. A compare process checks the DUT against
//   that model every cycle; directed checks pin bit values and frame lengths
//   with hand-computed literals. Define UART_TX_PARITY_EN for the parity build.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int NB_DATA = 8;
    localparam int N_OVS   = 16;
    localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
    localparam int LIT_FRAME = 176;
`else
    localparam int PAR_BITS = 0;
    localparam int LIT_FRAME = 160;
`endif
    localparam int FRAME_TICKS = (1 + NB_DATA + PAR_BITS) * N_OVS + SB_TICK;

    // ---------------- clock / reset ----------------
    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_tick;
    logic               i_tx_start;
    logic [NB_DATA-1:0] i_data;
    logic               o_tx, o_busy, o_tx_done;

    always #5 i_clk = ~i_clk;

    uart_tx #(
        .NB_DATA (NB_DATA),
        .SB_TICK (SB_TICK),
        .N_OVS   (N_OVS)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_tick     (i_tick),
        .i_tx_start (i_tx_start),
        .i_data     (i_data),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_tx_done  (o_tx_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cmp_fail_prints = 0;
    int tick_div = 1;
    int m_elapsed = 0;

    // ---------------- tick driver ----------------
    initial begin
        int div_cnt;
        div_cnt = 0;
        i_tick = 1'b0;
        forever begin
            @(negedge i_clk);
            if (tick_div <= 1) begin
                i_tick = 1'b1;
            end else begin
                i_tick = (div_cnt == 0);
                div_cnt = (div_cnt + 1) % tick_div;
            end
        end
    end

    // ---------------- frame model ----------------
    logic               m_valid  = 1'b0;
    logic               m_active = 1'b0;
    logic               m_done   = 1'b0;
    int                 m_n      = 0;
    logic [NB_DATA-1:0] m_word   = '0;

    always @(posedge i_clk) begin
        if (i_rst === 1'b0) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (!m_active) begin
            m_done = 1'b0;
            if (i_tx_start === 1'b1) begin
                m_active = 1'b1;
                m_n      = 0;
                m_word   = i_data;
            end
        end else begin
            m_done = 1'b0;
            if (i_tick === 1'b1) begin
                m_n = m_n + 1;
                if (m_n == FRAME_TICKS) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end
    end

    // Line level from the frame layout: segment 0 start, 1..NB_DATA data,
    // then optional parity, then stop.
    function automatic logic exp_tx();
        int seg;
        if (!m_active) return 1'b1;
        seg = m_n / N_OVS;
        if (seg == 0) return 1'b0;
        if (seg <= NB_DATA) return m_word[seg-1];
        if (PAR_BITS == 1 && seg == NB_DATA + 1) return ^m_word;
        return 1'b1;
    endfunction

    // ---------------- scoreboard ----------------
    logic [2:0] exp_q[$];

    always @(negedge i_clk) begin
        logic [2:0] exp_v, act_v;
        if (m_valid) begin
            exp_q.push_back({exp_tx(), m_active, m_done});
            exp_v = exp_q.pop_front();
            act_v = {o_tx, o_busy, o_tx_done};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                if (cmp_fail_prints < 20) begin
                    cmp_fail_prints++;
                    $display("FAIL model_cmp t=%0t {tx,busy,done} got %b expected %b",
                             $time, act_v, exp_v);
                end
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns just after the accept edge; m_elapsed counts edges since it.
    task automatic send(input logic [NB_DATA-1:0] d);
        @(negedge i_clk);
        i_tx_start = 1'b1;
        i_data     = d;
        @(negedge i_clk);
        i_tx_start = 1'b0;
        m_elapsed  = 0;
    endtask

    task automatic advance_to(input int target);
        while (m_elapsed < target) begin
            @(negedge i_clk);
            m_elapsed++;
        end
    endtask

    task automatic wait_done(input int budget);
        int guard;
        guard = 0;
        while (o_tx_done !== 1'b1 && guard < budget) begin
            @(negedge i_clk);
            m_elapsed++;
            guard++;
        end
        if (o_tx_done !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done timeout after %0d cycles", budget);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic exp2 [9];
        logic exp4 [8];
        exp2 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp4 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // 1: reset held with a pending request
        i_rst      = 1'b0;
        i_tx_start = 1'b1;
        i_data     = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("rst_tx", {31'd0, o_tx}, 32'd1);
            check("rst_busy", {31'd0, o_busy}, 32'd0);
            check("rst_done", {31'd0, o_tx_done}, 32'd0);
        end
        i_tx_start = 1'b0;
        i_rst      = 1'b1;
        repeat (3) @(negedge i_clk);

        // 2: tick every cycle, 0x55
        tick_div = 1;
        send(8'h55);
        for (int s = 0; s < 9; s++) begin
            advance_to(16 * s + 8);
            check($sformatf("t2_seg%0d", s), {31'd0, o_tx}, {31'd0, exp2[s]});
        end
`ifndef UART_TX_PARITY_EN
        advance_to(16 * 9 + 8);
        check("t2_stop", {31'd0, o_tx}, 32'd1);
`endif
        advance_to(LIT_FRAME - 1);
        check("t2_busy_end", {31'd0, o_busy}, 32'd1);
        check("t2_done_early", {31'd0, o_tx_done}, 32'd0);
        advance_to(LIT_FRAME);
        check("t2_done", {31'd0, o_tx_done}, 32'd1);
        check("t2_busy_clr", {31'd0, o_busy}, 32'd0);
        advance_to(LIT_FRAME + 1);
        check("t2_done_pulse", {31'd0, o_tx_done}, 32'd0);

`ifdef UART_TX_PARITY_EN
        // 3: parity bit values and frame length
        send(8'h55);
        advance_to(16 * 9 + 8);
        check("t3_par55", {31'd0, o_tx}, 32'd0);
        wait_done(400);
        check("t3_len55", m_elapsed, 32'd176);
        send(8'h07);
        advance_to(16 * 9 + 8);
        check("t3_par07", {31'd0, o_tx}, 32'd1);
        wait_done(400);
        check("t3_len07", m_elapsed, 32'd176);
`endif

        // 4: tick every 4th cycle, 0xA3
        tick_div = 4;
        repeat (2) @(negedge i_clk);
        send(8'hA3);
        advance_to(32);
        check("t4_start", {31'd0, o_tx}, 32'd0);
        for (int s = 0; s < 8; s++) begin
            advance_to(64 * (s + 1) + 32);
            check($sformatf("t4_bit%0d", s), {31'd0, o_tx}, {31'd0, exp4[s]});
        end
        wait_done(1200);
        tick_div = 1;
        repeat (4) @(negedge i_clk);

        // 5: request mid-frame is ignored; request in the done cycle is taken
        send(8'h00);
        advance_to(40);
        @(negedge i_clk);
        i_tx_start = 1'b1;
        i_data     = 8'hFF;
        @(negedge i_clk);
        i_tx_start = 1'b0;
        m_elapsed  = m_elapsed + 2;
        advance_to(16 * 8 + 8);
        check("t5_data_intact", {31'd0, o_tx}, 32'd0);
        wait_done(400);
        check("t5_len", m_elapsed, LIT_FRAME);
        i_tx_start = 1'b1;
        i_data     = 8'h3C;
        @(negedge i_clk);
        i_tx_start = 1'b0;
        m_elapsed  = 0;
        check("t5_b2b_start", {31'd0, o_tx}, 32'd0);
        check("t5_b2b_busy", {31'd0, o_busy}, 32'd1);
        advance_to(16 * 3 + 8);
        check("t5_3c_bit2", {31'd0, o_tx}, 32'd1);
        wait_done(400);
        repeat (50) @(negedge i_clk);
        check("t5_no_extra", {31'd0, o_busy}, 32'd0);

        // 6: reset during data bit 4, then a clean frame
        send(8'hA5);
        advance_to(88);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("t6_rst_tx", {31'd0, o_tx}, 32'd1);
        check("t6_rst_busy", {31'd0, o_busy}, 32'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("t6_idle_tx", {31'd0, o_tx}, 32'd1);
        send(8'h96);
        advance_to(16 * 2 + 8);
        check("t6_96_bit1", {31'd0, o_tx}, 32'd1);
        wait_done(400);
        check("t6_len", m_elapsed, LIT_FRAME);
        repeat (5) @(negedge i_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL global_timeout reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_tx
